// File: rtl/rgb_to_gray.sv
// RGB888 byte stream to 8-bit gray; 4-byte width/height header passes through.
// Define RGB_TO_GRAY_ROUND_EN to round the weighted sum instead of truncating.
module rgb_to_gray #(
  parameter int unsigned COEF_R = 77,
  parameter int unsigned COEF_G = 150,
  parameter int unsigned COEF_B = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  input  logic       ready_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HEADER = 2'd1;
  localparam logic [1:0] S_PIXEL  = 2'd2;

  localparam logic [15:0] W_CR = 16'(COEF_R);
  localparam logic [15:0] W_CG = 16'(COEF_G);
  localparam logic [15:0] W_CB = 16'(COEF_B);

  logic [1:0]  r_state;
  logic [1:0]  r_hcnt;
  logic [1:0]  r_ch;
  logic [31:0] r_pix;
  logic [31:0] r_total;
  logic [15:0] r_width;
  logic [15:0] r_height;
  logic [7:0]  r_red;
  logic [7:0]  r_grn;

  logic        w_acc;
  logic [15:0] w_sum;
  logic [15:0] w_rnd;
  logic [7:0]  w_gray;
  logic [31:0] w_total;
  logic [31:0] w_pix_nxt;

  assign ready_in = !valid_out || ready_out;
  assign w_acc    = valid_in && ready_in;

  assign w_sum = W_CR * {8'd0, r_red}
               + W_CG * {8'd0, r_grn}
               + W_CB * {8'd0, data_in};

`ifdef RGB_TO_GRAY_ROUND_EN
  assign w_rnd = w_sum + 16'd128;
`else
  assign w_rnd = w_sum;
`endif

  assign w_gray    = w_rnd[15:8];
  // Height high byte is the byte being accepted on the last header beat
  assign w_total   = {16'd0, r_width} * {16'd0, data_in, r_height[7:0]};
  assign w_pix_nxt = r_pix + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_hcnt    <= 2'd0;
      r_ch      <= 2'd0;
      r_pix     <= 32'd0;
      r_total   <= 32'd0;
      r_width   <= 16'd0;
      r_height  <= 16'd0;
      r_red     <= 8'd0;
      r_grn     <= 8'd0;
      data_out  <= 8'd0;
      valid_out <= 1'b0;
    end else begin
      if (valid_out && ready_out) valid_out <= 1'b0;
      if (w_acc) begin
        unique case (1'b1)
          (r_state == S_IDLE): begin
            r_width[7:0] <= data_in;
            r_hcnt       <= 2'd1;
            r_ch         <= 2'd0;
            r_pix        <= 32'd0;
            data_out     <= data_in;
            valid_out    <= 1'b1;
            r_state      <= S_HEADER;
          end
          (r_state == S_HEADER): begin
            data_out  <= data_in;
            valid_out <= 1'b1;
            r_hcnt    <= r_hcnt + 2'd1;
            unique case (1'b1)
              (r_hcnt == 2'd1): r_width[15:8]  <= data_in;
              (r_hcnt == 2'd2): r_height[7:0]  <= data_in;
              default: begin
                r_height[15:8] <= data_in;
                r_total        <= w_total;
                r_pix          <= 32'd0;
                r_ch           <= 2'd0;
                r_state <= (w_total == 32'd0) ? S_IDLE : S_PIXEL;
              end
            endcase
          end
          (r_state == S_PIXEL): begin
            unique case (1'b1)
              (r_ch == 2'd0): begin
                r_red <= data_in;
                r_ch  <= 2'd1;
              end
              (r_ch == 2'd1): begin
                r_grn <= data_in;
                r_ch  <= 2'd2;
              end
              default: begin
                data_out  <= w_gray;
                valid_out <= 1'b1;
                r_ch      <= 2'd0;
                r_pix     <= w_pix_nxt;
                if (w_pix_nxt == r_total) r_state <= S_IDLE;
              end
            endcase
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rgb_to_gray.sv
// Directed bench for rgb_to_gray: header passthrough, gray values,
// backpressure hold, zero-size frames and mid-frame reset.
module tb_rgb_to_gray;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ready_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q[$];

`ifdef RGB_TO_GRAY_ROUND_EN
  localparam logic [7:0] G010 = 8'h01;
`else
  localparam logic [7:0] G010 = 8'h00;
`endif

  rgb_to_gray dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output transfers recorded between edges; inputs only move at negedge
  always @(negedge clk) begin
    #2;
    if (valid_out && ready_out && !rst) q.push_back(data_out);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    data_in  = b;
    valid_in = 1'b1;
    while (!ready_in && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = 8'h00;
  endtask

  task automatic send(input logic [7:0] v[$]);
    foreach (v[i]) push(v[i]);
  endtask

  task automatic expect_q(input string tag, input logic [7:0] e[$]);
    int k;
    k = 0;
    while (q.size() < e.size() && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_count"}, q.size(), e.size());
    foreach (e[i])
      chk($sformatf("%s_b%0d", tag, i),
          (i < q.size()) ? {24'd0, q[i]} : 32'hxxxx_xxxx,
          {24'd0, e[i]});
    q.delete();
  endtask

  initial begin
    rst       = 1'b1;
    data_in   = 8'h00;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    #1;
    chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("rst_data_out",  {24'd0, data_out},  32'd0);
    chk("rst_ready_in",  {31'd0, ready_in},  32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send('{8'h02, 8'h00, 8'h01, 8'h00,
           8'hFF, 8'hFF, 8'hFF, 8'h64, 8'h32, 8'hC8});
    expect_q("f2x1", '{8'h02, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h52});

    send('{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00});
    expect_q("g010", '{8'h01, 8'h00, 8'h01, 8'h00, G010});

    send('{8'h00, 8'h00, 8'h05, 8'h00});
    expect_q("zero_w", '{8'h00, 8'h00, 8'h05, 8'h00});

    // New frame after zero-size frame, last pixel under backpressure
    send('{8'h01, 8'h00, 8'h01, 8'h00, 8'h80, 8'h80});
    expect_q("hdr_after_zero", '{8'h01, 8'h00, 8'h01, 8'h00});
    ready_out = 1'b0;
    push(8'h80);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold_valid_%0d", i), {31'd0, valid_out}, 32'd1);
      chk($sformatf("hold_data_%0d", i), {24'd0, data_out}, 32'h80);
      chk($sformatf("hold_rdy_%0d", i), {31'd0, ready_in}, 32'd0);
      @(negedge clk);
    end
    chk("hold_no_xfer", q.size(), 32'd0);
    ready_out = 1'b1;
    expect_q("hold_release", '{8'h80});
    chk("drained_valid", {31'd0, valid_out}, 32'd0);

    // Asynchronous reset clears a pending output without a clock edge
    ready_out = 1'b0;
    push(8'h5A);
    chk("pend_valid", {31'd0, valid_out}, 32'd1);
    chk("pend_data", {24'd0, data_out}, 32'h5A);
    #3 rst = 1'b1;
    #1;
    chk("async_valid", {31'd0, valid_out}, 32'd0);
    chk("async_data", {24'd0, data_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ready_out = 1'b1;
    @(negedge clk);
    q.delete();

    // Reset after R,G of first pixel in a 2x2 frame
    send('{8'h02, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22});
    expect_q("pre_rst_hdr", '{8'h02, 8'h00, 8'h02, 8'h00});
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    q.delete();
    send('{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01});
    expect_q("post_rst", '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rgb_to_gray.md
RGB_TO_GRAY -- requirements
Module: rgb_to_gray

Interface
REQ-001 Parameter: COEF_R, 77, red weight (unsigned 8-bit).
REQ-002 Parameter: COEF_G, 150, green weight (unsigned 8-bit).
REQ-003 Parameter: COEF_B, 29, blue weight (unsigned 8-bit); COEF_R+COEF_G+COEF_B SHALL equal 256.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 data_in  input  8  upstream byte (UART RX stream).
REQ-008 valid_in  input  1  data_in valid this cycle.
REQ-009 ready_in  output  1  block accepts data_in this cycle.
REQ-010 data_out  output  8  byte to sobel stage (header or gray pixel).
REQ-011 valid_out  output  1  data_out valid.
REQ-012 ready_out  input  1  downstream accepts data_out.

Function
REQ-013 Input stream SHALL be: width[7:0], width[15:8], height[7:0], height[15:8], then width*height pixels as R,G,B bytes.
REQ-014 Output stream SHALL be: the same 4 header bytes unchanged, then one gray byte per pixel.
REQ-015 Input transfer occurs when valid_in && ready_in; output transfer when valid_out && ready_out.
REQ-016 ready_in SHALL equal !valid_out || ready_out (single output register, no skid buffer).
REQ-017 States: IDLE, HEADER, PIXEL; IDLE->HEADER on first accepted byte (width[7:0]).
REQ-018 HEADER: latch width/height bytes; each header byte loads output register next cycle; after 4th accepted byte -> PIXEL, or -> IDLE if width==0 or height==0.
REQ-019 PIXEL: channel counter 0..2 selects R,G,B; R and G registered; on B accepted, gray loads output register next cycle (latency 1 clk from B acceptance to valid_out).
REQ-020 Gray = (COEF_R*R + COEF_G*G + COEF_B*B) >> 8 using 16-bit unsigned accumulator; result 8 bits, no saturation needed.
REQ-021 Pixel counter 32-bit, compared against width*height computed once on leaving HEADER.
REQ-022 After last pixel's B byte accepted -> IDLE; final gray byte still held until ready_out.
REQ-023 In IDLE, a new byte starts a new frame even while final gray byte awaits ready_out (held by ready_in=0 until drained).
REQ-024 While valid_out && !ready_out, data_out and valid_out SHALL hold stable.
REQ-025 Bytes with valid_in high while ready_in low are not consumed; upstream repeats them.

Reset
REQ-026 rst SHALL asynchronously force state=IDLE, valid_out=0, data_out=0, channel counter=0, pixel counter=0, width=0, height=0.
REQ-027 Reset mid-frame SHALL discard partial pixel and pending output; next accepted byte after release is width[7:0].

Configuration
REQ-028 Macro RGB_TO_GRAY_ROUND_EN: when defined, gray = (weighted sum + 128) >> 8; when undefined, truncation per REQ-020; max result 255 in both cases.

Verification
REQ-029 Header 02 00 01 00, pixels (255,255,255),(100,50,200), ready_out=1 -> out 02 00 01 00 FF 52, then IDLE.
REQ-030 Header 01 00 01 00, pixel (0,1,0) -> gray 00 without RGB_TO_GRAY_ROUND_EN, 01 with it.
REQ-031 Header 00 00 05 00 -> 4 header bytes output, return to IDLE; next byte treated as new width[7:0].
REQ-032 Pixel (128,128,128) with ready_out low 5 cycles after valid_out -> data_out=80 stable, ready_in=0 throughout, transfer on ready_out rise.
REQ-033 rst pulsed after R,G of pixel 1 of a 2x2 frame -> valid_out=0 immediately; fresh 01 00 01 00 + (0,0,1) -> 01 00 01 00 00.
